lcd1602_responder: RTL and testbench
====================================

LCD1602_RESPONDER -- requirements
Module: lcd1602_responder

Interface
REQ-001 Parameter BUSY_CMD_CYC, default 2000, busy length in clk cycles for any non-clear command or data write.
REQ-002 Parameter BUSY_CLR_CYC, default 82000, busy length in clk cycles for clear display (0x01).
REQ-003 clk  in  1  single clock for the whole block.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 lcd_rs  in  1  register select (0 = command, 1 = data), sampled at lcd_en fall.
REQ-006 lcd_rw  in  1  read/write (0 = write), sampled at lcd_en fall.
REQ-007 lcd_en  in  1  strobe; an access is accepted on its falling edge.
REQ-008 lcd_data  in  8  command or character byte.
REQ-009 rd_addr  in  7  DDRAM address for the readback port, same encoding as the LCD.
REQ-010 rd_data  out  8  DDRAM byte at rd_addr, registered, 1-cycle latency; 0x20 for invalid addresses.
REQ-011 ac  out  7  address counter.
REQ-012 disp_on, cursor_on, blink_on  out  1 each  display control bits D/C/B.
REQ-013 entry_inc  out  1  entry mode I/D bit.
REQ-014 func_8bit, func_2line  out  1 each  function set DL/N bits.
REQ-015 busy  out  1  controller busy.
REQ-016 err_busy, err_rw, err_addr  out  1 each  sticky protocol-violation flags.
REQ-017 wr_cnt  out  16  count of accepted data writes, saturating at 0xFFFF.

Function
REQ-018 lcd_en SHALL pass through a 2-flop synchronizer; a fall SHALL be detected when the stage-2 value is 0 and its previous value was 1; lcd_rs, lcd_rw and lcd_data SHALL be captured in the detection cycle.
REQ-019 Access effects (ac, flags, DDRAM, busy) SHALL be visible on the cycle after detection.
REQ-020 DDRAM SHALL hold 80 bytes; valid addresses are 0x00-0x27 (index addr) and 0x40-0x67 (index 40+addr[5:0]); all other addresses are invalid.
REQ-021 Command decode SHALL use the highest set bit: 0x80 set DDRAM address (ac <= data[6:0]); 0x40 set CGRAM address, ignored; 0x20 function set (DL = bit4, N = bit3); 0x10 shift, ignored; 0x08 display control (D = bit2, C = bit1, B = bit0); 0x04 entry mode (I/D = bit1, S ignored); 0x02 return home (ac <= 0); 0x01 clear; 0x00 no-op.
REQ-022 A data write SHALL store the byte at ac and then step ac by +1 if entry_inc = 1, otherwise by -1.
REQ-023 The ac step SHALL wrap: 0x27 -> 0x40, 0x67 -> 0x00, 0x00 -> 0x67, 0x40 -> 0x27.
REQ-024 A data write at an invalid ac SHALL be discarded, set err_addr, and leave ac unchanged.
REQ-025 Clear SHALL run a sweep of 80 consecutive cycles that writes 0x20 to every entry, then set ac = 0 and entry_inc = 1; busy SHALL be 1 throughout the sweep.
REQ-026 Any access detected during a clear sweep SHALL be dropped and SHALL set err_busy.
REQ-027 An access with lcd_rw = 1 SHALL be ignored and SHALL set err_rw.
REQ-028 wr_cnt SHALL increment only on data writes that are stored.
REQ-029 rd_data SHALL reflect the memory contents as of the previous cycle.
REQ-030 Error flags SHALL clear only on reset.

Reset
REQ-031 Reset SHALL set ac = 0, entry_inc = 1, func_8bit = 1, and all other control bits, busy, error flags and wr_cnt to 0.
REQ-032 Reset SHALL start a clear sweep; rd_data SHALL be 0x20 everywhere once the sweep completes (80 cycles after rst falls).
REQ-033 Reset asserted during a sweep or busy period SHALL abort it and restart per REQ-031 and REQ-032.

Configuration
REQ-034 With macro LCD_RESP_BUSY_TIMING_EN defined, each accepted access SHALL hold busy = 1 for BUSY_CMD_CYC cycles, or BUSY_CLR_CYC cycles for clear (the window includes the sweep).
REQ-035 With LCD_RESP_BUSY_TIMING_EN defined, an access detected while busy but outside a sweep SHALL execute normally and SHALL set err_busy.
REQ-036 Without LCD_RESP_BUSY_TIMING_EN, busy SHALL be 1 only during clear sweeps, and no timing counter SHALL exist.

Verification
REQ-037 Scenario: reset, then 0x38, 0x08, 0x01, 0x06, 0x0C spaced 100000 cycles apart -> func_8bit = 1, func_2line = 1, disp_on = 1, cursor_on = 0, blink_on = 0, entry_inc = 1, ac = 0x00, all rd_data = 0x20, no error flags set.
REQ-038 Scenario: 0x80, then data 0x76 and 0x65 -> rd_addr 0x00 returns 0x76, 0x01 returns 0x65, ac = 0x02, wr_cnt = 2.
REQ-039 Scenario: 0xA7, then data 0x41 and 0x42 -> DDRAM 0x27 = 0x41, 0x40 = 0x42, ac = 0x41.
REQ-040 Scenario: 0x04, 0x80, then data 0x78 -> DDRAM 0x00 = 0x78, ac = 0x67; then 0xB0 and data 0x31 -> discarded, err_addr = 1, ac = 0x30.
REQ-041 Scenario: 0x01, then an lcd_en fall 20 cycles later -> access dropped, err_busy = 1; separately, lcd_rw = 1 access -> err_rw = 1 with no state change.
REQ-042 Scenario: with the macro, 0x38 -> busy high exactly BUSY_CMD_CYC cycles; without the macro, busy stays 0; with the macro, 0x01 -> busy high exactly BUSY_CLR_CYC cycles.

Source files
------------

// File: rtl/lcd1602_responder.sv
// HD44780/LCD1602 bus responder: decodes writes on the lcd_en fall, mirrors the 80-byte DDRAM with a readback port.
// Optional macro LCD_RESP_BUSY_TIMING_EN adds a per-access busy window driven by a down-counter.
module lcd1602_responder #(
  parameter int BUSY_CMD_CYC = 2000,
  parameter int BUSY_CLR_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       busy,
  output logic       err_busy,
  output logic       err_rw,
  output logic       err_addr,
  output logic [15:0] wr_cnt
);

  function automatic logic addr_ok(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Line 2 (0x40..0x67) packs directly after line 1 in the 80-entry array
  function automatic logic [6:0] addr_idx(input logic [6:0] a);
    return a[6] ? (7'd40 + {1'b0, a[5:0]}) : a;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  logic       en_s1, en_s2, en_s2_prev;
  logic       sweep;
  logic [6:0] sweep_idx;
  logic [7:0] mem [0:79];
  logic [7:0] rd_raw;
  logic       rd_ok_reg;

  logic       fall, accept, is_clear, data_ok, we, rd_ok, busy_next;
  logic [6:0] waddr, rd_idx;
  logic [7:0] wdata;

`ifdef LCD_RESP_BUSY_TIMING_EN
  localparam int MAX_CYC = (BUSY_CLR_CYC > BUSY_CMD_CYC) ? BUSY_CLR_CYC : BUSY_CMD_CYC;
  localparam int TW = $clog2(MAX_CYC + 1);
  logic [TW-1:0] timer_reg, timer_next;
`endif

  always_comb begin
    fall     = en_s2_prev & ~en_s2;
    accept   = fall & ~sweep & ~lcd_rw;
    is_clear = accept & ~lcd_rs & (lcd_data == 8'h01);
    data_ok  = accept & lcd_rs & addr_ok(ac);
    we       = ~rst & (sweep | data_ok);
    waddr    = sweep ? sweep_idx : addr_idx(ac);
    wdata    = sweep ? 8'h20 : lcd_data;
    rd_ok    = addr_ok(rd_addr);
    rd_idx   = rd_ok ? addr_idx(rd_addr) : 7'd0;
`ifdef LCD_RESP_BUSY_TIMING_EN
    timer_next = timer_reg;
    if (accept)
      timer_next = is_clear ? TW'(BUSY_CLR_CYC) : TW'(BUSY_CMD_CYC);
    else if (timer_reg != '0)
      timer_next = timer_reg - 1'b1;
    busy_next = is_clear | (sweep & (sweep_idx != 7'd79)) | (timer_next != '0);
`else
    busy_next = is_clear | (sweep & (sweep_idx != 7'd79));
`endif
  end

`ifndef LCD_RESP_BUSY_TIMING_EN
  // Busy windows are not timed in this build; the parameters have nothing to size
  if (BUSY_CMD_CYC < 0 || BUSY_CLR_CYC < 0) begin : g_timing_unused
  end
`endif

  // DDRAM: one write port (sweep or data write), registered read-before-write
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rd_raw    <= mem[rd_idx];
    rd_ok_reg <= rd_ok;
  end

  assign rd_data = rd_ok_reg ? rd_raw : 8'h20;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_s1      <= 1'b0;
      en_s2      <= 1'b0;
      en_s2_prev <= 1'b0;
      sweep      <= 1'b1;
      sweep_idx  <= 7'd0;
      ac         <= 7'd0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      entry_inc  <= 1'b1;
      func_8bit  <= 1'b1;
      func_2line <= 1'b0;
      busy       <= 1'b0;
      err_busy   <= 1'b0;
      err_rw     <= 1'b0;
      err_addr   <= 1'b0;
      wr_cnt     <= 16'd0;
`ifdef LCD_RESP_BUSY_TIMING_EN
      timer_reg  <= '0;
`endif
    end else begin
      en_s1      <= lcd_en;
      en_s2      <= en_s1;
      en_s2_prev <= en_s2;
      busy       <= busy_next;
`ifdef LCD_RESP_BUSY_TIMING_EN
      timer_reg  <= timer_next;
`endif
      if (sweep) begin
        if (sweep_idx == 7'd79) begin
          sweep     <= 1'b0;
          ac        <= 7'd0;
          entry_inc <= 1'b1;
        end else begin
          sweep_idx <= sweep_idx + 7'd1;
        end
      end
      if (fall) begin
        if (sweep) begin
          err_busy <= 1'b1;
        end else if (lcd_rw) begin
          err_rw <= 1'b1;
        end else begin
`ifdef LCD_RESP_BUSY_TIMING_EN
          if (timer_reg != '0)
            err_busy <= 1'b1;
`endif
          if (lcd_rs) begin
            if (addr_ok(ac)) begin
              ac <= ac_step(ac, entry_inc);
              if (wr_cnt != 16'hFFFF)
                wr_cnt <= wr_cnt + 16'd1;
            end else begin
              err_addr <= 1'b1;
            end
          end else begin
            casez (lcd_data)
              8'b1???????: ac <= lcd_data[6:0];
              8'b01??????: ;
              8'b001?????: begin
                func_8bit  <= lcd_data[4];
                func_2line <= lcd_data[3];
              end
              8'b0001????: ;
              8'b00001???: begin
                disp_on   <= lcd_data[2];
                cursor_on <= lcd_data[1];
                blink_on  <= lcd_data[0];
              end
              8'b000001??: entry_inc <= lcd_data[1];
              8'b0000001?: ac <= 7'd0;
              8'b00000001: begin
                sweep     <= 1'b1;
                sweep_idx <= 7'd0;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd1602_responder.sv
// Self-checking bench for lcd1602_responder: directed scenarios plus a random access stream
// compared against a byte-array model of the LCD's DDRAM and control registers.
module tb_lcd1602_responder;
  localparam int CMD_CYC  = 30;
  localparam int CLR_CYC  = 300;
  localparam int GAP      = 40;
`ifdef LCD_RESP_BUSY_TIMING_EN
  localparam int CLR_WAIT = CLR_CYC + 30;
  localparam int EXP_CMD_BUSY = CMD_CYC;
  localparam int EXP_CLR_BUSY = CLR_CYC;
`else
  localparam int CLR_WAIT = 120;
  localparam int EXP_CMD_BUSY = 0;
  localparam int EXP_CLR_BUSY = 80;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic disp_on, cursor_on, blink_on, entry_inc, func_8bit, func_2line, busy;
  logic err_busy, err_rw, err_addr;
  logic [15:0] wr_cnt;

  lcd1602_responder #(.BUSY_CMD_CYC(CMD_CYC), .BUSY_CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .entry_inc(entry_inc), .func_8bit(func_8bit), .func_2line(func_2line),
    .busy(busy), .err_busy(err_busy), .err_rw(err_rw), .err_addr(err_addr),
    .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int busy_hi = 0;

  // Reference model, indexed by raw LCD address
  logic [7:0] m_mem [128];
  int m_ac, m_cnt;
  bit m_inc, m_d, m_c, m_b, m_dl, m_n, m_eb, m_erw, m_ea;

  function automatic bit m_ok(input int a);
    return (a >= 0 && a <= 39) || (a >= 64 && a <= 103);
  endfunction

  function automatic int m_next(input int a, input bit inc);
    if (inc) return (a == 39) ? 64 : (a == 103) ? 0 : a + 1;
    return (a == 0) ? 103 : (a == 64) ? 39 : a - 1;
  endfunction

  task automatic m_clear_mem();
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
  endtask

  task automatic m_reset();
    m_clear_mem();
    m_ac = 0; m_cnt = 0; m_inc = 1; m_dl = 1;
    m_d = 0; m_c = 0; m_b = 0; m_n = 0; m_eb = 0; m_erw = 0; m_ea = 0;
  endtask

  task automatic m_apply(input bit rs, input bit rw, input logic [7:0] d);
    int v;
    v = int'(d);
    if (rw) m_erw = 1;
    else if (rs) begin
      if (m_ok(m_ac)) begin
        m_mem[m_ac] = d;
        m_ac = m_next(m_ac, m_inc);
        if (m_cnt < 65535) m_cnt++;
      end else m_ea = 1;
    end else if (v >= 128) m_ac = v - 128;
    else if (v >= 64) ;
    else if (v >= 32) begin m_dl = d[4]; m_n = d[3]; end
    else if (v >= 16) ;
    else if (v >= 8) begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
    else if (v >= 4) m_inc = d[1];
    else if (v >= 2) m_ac = 0;
    else if (v == 1) begin m_clear_mem(); m_ac = 0; m_inc = 1; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ac"}, 32'(ac), 32'(m_ac));
    check({tag, ".entry_inc"}, 32'(entry_inc), 32'(m_inc));
    check({tag, ".disp_on"}, 32'(disp_on), 32'(m_d));
    check({tag, ".cursor_on"}, 32'(cursor_on), 32'(m_c));
    check({tag, ".blink_on"}, 32'(blink_on), 32'(m_b));
    check({tag, ".func_8bit"}, 32'(func_8bit), 32'(m_dl));
    check({tag, ".func_2line"}, 32'(func_2line), 32'(m_n));
    check({tag, ".err_busy"}, 32'(err_busy), 32'(m_eb));
    check({tag, ".err_rw"}, 32'(err_rw), 32'(m_erw));
    check({tag, ".err_addr"}, 32'(err_addr), 32'(m_ea));
    check({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(m_cnt));
    $display("state %s: ac=%02h wr_cnt=%0d flags=%b%b%b", tag, ac, wr_cnt, err_busy, err_rw, err_addr);
  endtask

  task automatic rd_check(input string tag, input int a);
    logic [7:0] exp;
    @(negedge clk);
    rd_addr = 7'(a);
    @(negedge clk);
    exp = m_ok(a) ? m_mem[a] : 8'h20;
    check($sformatf("%s.rd[%02h]", tag, a), 32'(rd_data), 32'(exp));
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 128; a++) rd_check(tag, a);
    $display("ddram %s compared over 128 addresses", tag);
  endtask

  // One bus access: data set up with the rising strobe, held stable well past the fall
  task automatic access(input bit rs, input bit rw, input logic [7:0] d, input int wait_cyc,
                        input bit dropped);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
    busy_hi = 0;
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    if (dropped) m_eb = 1;
    else m_apply(rs, rw, d);
    $display("access rs=%0d rw=%0d data=%02h dropped=%0d busy_cycles=%0d ac=%02h",
             rs, rw, d, dropped, busy_hi, ac);
  endtask

  initial begin
    logic [7:0] d;
    int r, idx;

    m_reset();
    repeat (4) @(negedge clk);
    check_state("reset");
    check("reset.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("post_reset.busy", 32'(busy), 32'd0);
    check_mem("post_reset");

    // Power-up style initialisation sequence
    access(0, 0, 8'h38, GAP, 0);
    check("busy_len.cmd", 32'(busy_hi), 32'(EXP_CMD_BUSY));
    access(0, 0, 8'h08, GAP, 0);
    access(0, 0, 8'h01, CLR_WAIT, 0);
    check("busy_len.clear", 32'(busy_hi), 32'(EXP_CLR_BUSY));
    access(0, 0, 8'h06, GAP, 0);
    access(0, 0, 8'h0C, GAP, 0);
    check_state("init");
    check("init.disp_on_direct", 32'(disp_on), 32'd1);

    // Sequential writes on line 1
    access(0, 0, 8'h80, GAP, 0);
    access(1, 0, 8'h76, GAP, 0);
    access(1, 0, 8'h65, GAP, 0);
    check_state("line1");
    rd_check("line1", 8'h00);
    rd_check("line1", 8'h01);

    // Wrap from end of line 1 to start of line 2
    access(0, 0, 8'hA7, GAP, 0);
    access(1, 0, 8'h41, GAP, 0);
    access(1, 0, 8'h42, GAP, 0);
    check_state("wrap_inc");
    rd_check("wrap_inc", 8'h27);
    rd_check("wrap_inc", 8'h40);

    // Decrement wrap 0x00 -> 0x67, then write at an invalid address
    access(0, 0, 8'h04, GAP, 0);
    access(0, 0, 8'h80, GAP, 0);
    access(1, 0, 8'h78, GAP, 0);
    check_state("wrap_dec");
    access(0, 0, 8'hB0, GAP, 0);
    access(1, 0, 8'h31, GAP, 0);
    check_state("bad_addr");
    rd_check("wrap_dec", 8'h00);

    // Access during a clear sweep is dropped
    access(0, 0, 8'h01, 17, 0);
    access(1, 0, 8'h55, CLR_WAIT, 1);
    check_state("drop_sweep");
    // Read access is ignored
    access(0, 1, 8'h38, GAP, 0);
    check_state("read_access");

    // Random access stream
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) access(1, 0, 8'($urandom), GAP, 0);
      else if (r == 5) begin
        if ($urandom_range(0, 9) < 7) begin
          idx = $urandom_range(0, 79);
          d = 8'h80 | 8'((idx < 40) ? idx : idx + 24);
        end else d = 8'h80 | 8'($urandom_range(0, 127));
        access(0, 0, d, GAP, 0);
      end else if (r == 6) access(0, 0, 8'h04 | 8'($urandom_range(0, 3)), GAP, 0);
      else if (r == 7) access(0, 0, 8'h02 | 8'($urandom_range(0, 1)), GAP, 0);
      else if (r == 8) begin
        d = 8'($urandom_range(0, 127));
        if (d == 8'h01) d = 8'h00;
        access(0, 0, d, GAP, 0);
      end else access(1'($urandom_range(0, 1)), 1, 8'($urandom), GAP, 0);
    end
    check_state("random");
    check_mem("random");

    // Reset in the middle of a clear sweep restarts everything
    access(0, 0, 8'h01, 30, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    m_reset();
    check_state("mid_reset");
    check("mid_reset.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_mem("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
